ext_uart_slave: RTL and testbench

EXT_UART_SLAVE -- requirements
Module: ext_uart_slave

---
 rtl/ext_uart_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/ext_uart_slave.sv | 241 ++++++++++++++++++++++++
 tb/tb_ext_uart_slave.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_uart_pkg.sv
// Shared register map, STATUS/CTRL bit positions and FSM state types for ext_uart_slave.
package ext_uart_pkg;

    localparam logic [9:0] ADR_DATA   = 10'h000;
    localparam logic [9:0] ADR_STATUS = 10'h001;
    localparam logic [9:0] ADR_DIV_LO = 10'h002;
    localparam logic [9:0] ADR_DIV_HI = 10'h003;
    localparam logic [9:0] ADR_CTRL   = 10'h004;
    localparam logic [9:0] ADR_RXPOP  = 10'h005;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_TX_BUSY    = 4;
    localparam int ST_TX_DROP    = 5;
    localparam int ST_FRAME_ERR  = 6;

    localparam int CTRL_CLR_OVERRUN = 0;
    localparam int CTRL_CLR_DROP    = 1;
    localparam int CTRL_CLR_FRAME   = 2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // push/pop are single-cycle requests: a pop on empty is ignored, a push is
    // accepted when not full or when a pop frees a slot in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ext_uart_slave.sv
// Byte-addressed UART slave: TX/RX FIFOs, 8N1 shifters, programmable 16-bit divisor.
module ext_uart_slave
    import ext_uart_pkg::*;
#(
    parameter int DIV_RESET  = 233,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] ext_adr,
    input  logic [7:0] ext_do,
    input  logic       ext_oe,
    output logic [7:0] ext_di,
    input  logic       uart_rx,
    output logic       uart_tx
);

    logic        wr_data, wr_pop, wr_ctrl, wr_div_lo, wr_div_hi;
    logic [15:0] divisor;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]  tx_head, rx_head;
    logic        tx_drop, rx_overrun, frame_err;
    logic [7:0]  status, rd_data;

    tx_state_t   tx_state, tx_next;
    logic [15:0] tx_cnt, tx_bit_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_bit_end, tx_load, tx_busy;

    rx_state_t   rx_state, rx_next;
    logic        rx_sync1, rx_sync2, rx_prev;
    logic [15:0] rx_cnt, rx_bit_div;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_mid_start, rx_bit_end, rx_done, rx_ferr;

    assign wr_data   = ext_oe && (ext_adr == ADR_DATA);
    assign wr_pop    = ext_oe && (ext_adr == ADR_RXPOP);
    assign wr_ctrl   = ext_oe && (ext_adr == ADR_CTRL);
    assign wr_div_lo = ext_oe && (ext_adr == ADR_DIV_LO);
    assign wr_div_hi = ext_oe && (ext_adr == ADR_DIV_HI);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(wr_data), .pop(tx_load), .din(ext_do),
        .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_done), .pop(wr_pop), .din(rx_shift),
        .full(rx_full), .empty(rx_empty), .head(rx_head)
    );

    // Registers and sticky flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divisor    <= 16'(DIV_RESET);
            tx_drop    <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (wr_div_lo) divisor[7:0]  <= ext_do;
            if (wr_div_hi) divisor[15:8] <= ext_do;
            if (wr_data && tx_full && !tx_load)     tx_drop <= 1'b1;
            else if (wr_ctrl && ext_do[CTRL_CLR_DROP]) tx_drop <= 1'b0;
            if (rx_done && rx_full && !wr_pop)      rx_overrun <= 1'b1;
            else if (wr_ctrl && ext_do[CTRL_CLR_OVERRUN]) rx_overrun <= 1'b0;
            if (rx_ferr)                            frame_err <= 1'b1;
            else if (wr_ctrl && ext_do[CTRL_CLR_FRAME]) frame_err <= 1'b0;
        end
    end

    // ---------------- TX state machine ----------------
    assign tx_bit_end = (tx_cnt == tx_bit_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (!tx_empty) tx_next = TX_START;
            TX_START: if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_next = tx_empty ? TX_IDLE : TX_START;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        tx_load = 1'b0;
        case (tx_state)
            TX_IDLE:  tx_load = !tx_empty;
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = tx_shift[0];
            TX_STOP:  tx_load = tx_bit_end && !tx_empty;
            default:  uart_tx = 1'b1;
        endcase
    end

    assign tx_busy = (tx_state != TX_IDLE);

    // Divisor is relatched at every bit boundary so changes apply cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt     <= '0;
            tx_bit_div <= 16'(DIV_RESET);
            tx_bit     <= '0;
            tx_shift   <= 8'hFF;
        end else if (tx_load) begin
            tx_shift   <= tx_head;
            tx_cnt     <= '0;
            tx_bit_div <= divisor;
            tx_bit     <= '0;
        end else if (tx_state != TX_IDLE) begin
            if (tx_bit_end) begin
                tx_cnt     <= '0;
                tx_bit_div <= divisor;
                if (tx_state == TX_DATA) begin
                    tx_shift <= {1'b1, tx_shift[7:1]};
                    tx_bit   <= tx_bit + 3'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    // ---------------- RX state machine ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= uart_rx;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
        end
    end

    assign rx_mid_start = (rx_cnt == (rx_bit_div >> 1));
    assign rx_bit_end   = (rx_cnt == rx_bit_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync2) rx_next = RX_START;
            RX_START: if (rx_mid_start) rx_next = rx_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_bit_end) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_done = 1'b0;
        rx_ferr = 1'b0;
        if (rx_state == RX_STOP && rx_bit_end) begin
            rx_done = rx_sync2;
            rx_ferr = !rx_sync2;
        end
    end

    // After the half-bit recheck, each full bit period lands on mid-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_cnt     <= '0;
            rx_bit_div <= 16'(DIV_RESET);
            rx_bit     <= '0;
            rx_shift   <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt     <= '0;
                    rx_bit_div <= divisor;
                    rx_bit     <= '0;
                end
                RX_START: begin
                    if (rx_mid_start) begin
                        rx_cnt     <= '0;
                        rx_bit_div <= divisor;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt     <= '0;
                        rx_bit_div <= divisor;
                        rx_shift   <= {rx_sync2, rx_shift[7:1]};
                        rx_bit     <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_bit_end) rx_cnt <= '0;
                    else            rx_cnt <= rx_cnt + 16'd1;
                end
            endcase
        end
    end

    // ---------------- Read path ----------------
    always_comb begin
        status                = '0;
        status[ST_TX_FULL]    = tx_full;
        status[ST_TX_EMPTY]   = tx_empty;
        status[ST_RX_VALID]   = !rx_empty;
        status[ST_RX_OVERRUN] = rx_overrun;
        status[ST_TX_BUSY]    = tx_busy;
        status[ST_TX_DROP]    = tx_drop;
        status[ST_FRAME_ERR]  = frame_err;
    end

    always_comb begin
        rd_data = 8'h00;
        case (ext_adr)
            ADR_DATA:   rd_data = rx_empty ? 8'h00 : rx_head;
            ADR_STATUS: rd_data = status;
            ADR_DIV_LO: rd_data = divisor[7:0];
            ADR_DIV_HI: rd_data = divisor[15:8];
            default:    rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ext_di <= 8'h00;
        else       ext_di <= rd_data;
    end

endmodule

// File: tb/tb_ext_uart_slave.sv
// Directed bench for ext_uart_slave: read and serial-TX scoreboards fed by driver tasks.
module tb_ext_uart_slave;
    import ext_uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] ext_adr;
    logic [7:0] ext_do;
    logic       ext_oe;
    logic [7:0] ext_di;
    logic       uart_rx;
    logic       uart_tx;

    int checks = 0;
    int errors = 0;
    int tb_div = 233;

    logic [7:0] exp_q[$];
    string      name_q[$];
    logic [7:0] tx_exp_q[$];

    logic rd_req = 1'b0;
    logic rd_pending = 1'b0;

    ext_uart_slave dut (
        .clk(clk), .reset(reset), .ext_adr(ext_adr), .ext_do(ext_do), .ext_oe(ext_oe),
        .ext_di(ext_di), .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- read monitor ----------------
    logic [7:0] mon_e;
    string      mon_n;

    always @(posedge clk or posedge reset) begin
        if (reset) rd_pending <= 1'b0;
        else       rd_pending <= rd_req;
    end

    always @(negedge clk) begin
        if (rd_pending) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: ext_di=0x%02h with no expected value queued", ext_di);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                if (ext_di !== mon_e) begin
                    errors++;
                    $display("FAIL %s: ext_di=0x%02h expected 0x%02h", mon_n, ext_di, mon_e);
                end
            end
        end
    end

    // ---------------- serial TX monitor ----------------
    logic       tm_act = 1'b0;
    logic       tm_noexp;
    logic       tm_bad;
    int         tm_cnt;
    int         tm_len;
    int         tm_idx;
    logic [9:0] tm_exp;
    logic [9:0] tm_got;

    always @(negedge clk) begin
        if (reset) begin
            tm_act = 1'b0;
            tx_exp_q.delete();
        end else begin
            if (!tm_act && uart_tx !== 1'b1) begin
                tm_act   = 1'b1;
                tm_cnt   = 0;
                tm_bad   = 1'b0;
                tm_len   = tb_div + 1;
                tm_got   = '0;
                tm_noexp = (tx_exp_q.size() == 0);
                if (tm_noexp) begin
                    checks++;
                    errors++;
                    tm_exp = 10'h3FE;
                    $display("FAIL tx_unexpected: start bit seen with no byte queued");
                end else begin
                    tm_exp = {1'b1, tx_exp_q.pop_front(), 1'b0};
                end
            end
            if (tm_act) begin
                tm_idx = tm_cnt / tm_len;
                if (uart_tx !== tm_exp[tm_idx]) tm_bad = 1'b1;
                if ((tm_cnt % tm_len) == (tm_len / 2)) tm_got[tm_idx] = uart_tx;
                tm_cnt++;
                if (tm_cnt == 10 * tm_len) begin
                    tm_act = 1'b0;
                    if (!tm_noexp) begin
                        checks++;
                        if (tm_bad) begin
                            errors++;
                            $display("FAIL tx_frame: line bits %b (stop..start, bad timing=%0d) expected %b",
                                     tm_got, tm_bad, tm_exp);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        ext_adr = a;
        ext_do  = d;
        ext_oe  = 1'b1;
        @(posedge clk);
        #1;
        ext_oe = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [7:0] e, input string n);
        ext_adr = a;
        rd_req  = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic hold_bit();
        repeat (tb_div + 1) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        hold_bit();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            hold_bit();
        end
        uart_rx = stop_bit;
        hold_bit();
        uart_rx = 1'b1;
    endtask

    task automatic check_val(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", n, act, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset   = 1'b1;
        ext_adr = '0;
        ext_do  = '0;
        ext_oe  = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_ext_di", ext_di, 8'h00);
        check_val("reset_uart_tx", {7'd0, uart_tx}, 8'h01);
        reset = 1'b0;
        idle(1);

        // reset register values
        rd(ADR_STATUS, 8'h02, "reset_status");
        rd(ADR_DATA,   8'h00, "reset_data_empty");
        rd(ADR_DIV_LO, 8'hE9, "reset_div_lo");
        rd(ADR_DIV_HI, 8'h00, "reset_div_hi");

        // divisor readback and unmapped addresses
        wr(ADR_DIV_LO, 8'h10);
        rd(ADR_DIV_LO, 8'h10, "div_lo_readback");
        rd(10'h3FF, 8'h00, "unmapped_3ff");
        rd(10'h006, 8'h00, "unmapped_006");
        wr(10'h3FF, 8'hFF);
        rd(ADR_STATUS, 8'h02, "status_after_unmapped_wr");
        rd(ADR_CTRL, 8'h00, "ctrl_reads_zero");

        // single frame 0xA5 at divisor 3
        wr(ADR_DIV_LO, 8'h03);
        tb_div = 3;
        tx_exp_q.push_back(8'hA5);
        wr(ADR_DATA, 8'hA5);
        idle(2);
        for (int i = 0; i < 8; i++) begin
            rd(ADR_STATUS, 8'h12, "tx_busy_mid_frame");
            idle(3);
        end
        idle(15);
        rd(ADR_STATUS, 8'h02, "tx_done_status");

        // overflow of the TX FIFO while the shifter is busy
        tx_exp_q.push_back(8'h11);
        wr(ADR_DATA, 8'h11);
        idle(2);
        tx_exp_q.push_back(8'h22);
        tx_exp_q.push_back(8'h33);
        tx_exp_q.push_back(8'h44);
        tx_exp_q.push_back(8'h55);
        wr(ADR_DATA, 8'h22);
        wr(ADR_DATA, 8'h33);
        wr(ADR_DATA, 8'h44);
        wr(ADR_DATA, 8'h55);
        wr(ADR_DATA, 8'h66);
        rd(ADR_STATUS, 8'h31, "tx_full_drop");
        wr(ADR_CTRL, 8'h02);
        rd(ADR_STATUS, 8'h11, "tx_drop_cleared");
        idle(220);
        rd(ADR_STATUS, 8'h02, "tx_drained");

        // receive 0x3C at divisor 7
        wr(ADR_DIV_LO, 8'h07);
        tb_div = 7;
        send_frame(8'h3C, 1'b1);
        idle(5);
        rd(ADR_STATUS, 8'h06, "rx_valid_status");
        rd(ADR_DATA,   8'h3C, "rx_data_3c");
        rd(ADR_DATA,   8'h3C, "rx_read_no_side_effect");
        wr(ADR_RXPOP, 8'h00);
        rd(ADR_STATUS, 8'h02, "rx_after_pop");
        rd(ADR_DATA,   8'h00, "rx_empty_data");
        wr(ADR_RXPOP, 8'h00);
        rd(ADR_STATUS, 8'h02, "rx_pop_on_empty");

        // RX overrun, ordering and framing error
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        idle(20);
        rd(ADR_STATUS, 8'h0E, "rx_overrun_status");
        for (int i = 1; i <= 4; i++) begin
            rd(ADR_DATA, 8'(i), "rx_order");
            wr(ADR_RXPOP, 8'h00);
        end
        rd(ADR_STATUS, 8'h0A, "rx_drained_overrun_sticky");
        send_frame(8'h77, 1'b0);
        idle(20);
        rd(ADR_STATUS, 8'h4A, "frame_err_set");
        rd(ADR_DATA,   8'h00, "frame_err_not_queued");
        wr(ADR_CTRL, 8'h05);
        rd(ADR_STATUS, 8'h02, "ctrl_clear_ovr_ferr");

        // reset in the middle of a TX frame and an RX frame
        tx_exp_q.push_back(8'h5A);
        wr(ADR_DATA, 8'h5A);
        uart_rx = 1'b0;
        idle(26);
        check_val("tx_low_before_reset", {7'd0, uart_tx}, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        check_val("tx_high_on_reset", {7'd0, uart_tx}, 8'h01);
        check_val("ext_di_on_reset", ext_di, 8'h00);
        idle(2);
        uart_rx = 1'b1;
        reset   = 1'b0;
        tb_div  = 233;
        idle(3);
        rd(ADR_STATUS, 8'h02, "status_after_mid_reset");
        rd(ADR_DIV_LO, 8'hE9, "div_lo_after_mid_reset");
        rd(ADR_DIV_HI, 8'h00, "div_hi_after_mid_reset");
        rd(ADR_DATA,   8'h00, "rx_partial_discarded");
        idle(5);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rd_queue_drain: %0d reads left, expected 0", exp_q.size());
        end
        checks++;
        if (tx_exp_q.size() != 0) begin
            errors++;
            $display("FAIL tx_queue_drain: %0d frames left, expected 0", tx_exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
